// File: rtl/sar_pkg.sv
// +----------------------------------------------------------------------+
// | sar_pkg : shared types and constants for the SAR search engine        |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package sar_pkg;

  localparam int SAR_WIDTH = 8;
  localparam int SAR_IDX_W = $clog2(SAR_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } sar_state_e;

endpackage

`default_nettype wire

// File: rtl/sar_search.sv
// +----------------------------------------------------------------------+
// | sar_search : successive-approximation recovery of a comparator's      |
// |              hidden operand, MSB first, one bit per cycle.            |
// | Option     : SAR_EARLY_EXIT_EN stops on the first equal verdict.      |
// | Rev 1.0    : initial release                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [WIDTH-1:0] trial_o,
  input  logic             greater_i,
  input  logic             less_i,
  input  logic             equal_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             found_o,
  output logic             err_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rfound_q, rfound_d;
  logic             rerr_q, rerr_d;

  logic [WIDTH-1:0] probe_bit;
  logic             verdict_ok;
  logic             keep_bit;

  assign probe_bit  = WIDTH'(1) << idx_q;
  assign verdict_ok = $onehot({greater_i, less_i, equal_i});
  assign keep_bit   = greater_i | equal_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      rfound_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
      rfound_q <= rfound_d;
      rerr_q   <= rerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    rfound_d = rfound_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = PROBE;
          acc_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          found_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      PROBE: begin
        if (!verdict_ok) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (keep_bit) acc_d = acc_q | probe_bit;
          if (equal_i) found_d = 1'b1;
          idx_d = idx_q - 1'b1;
          if (idx_q == '0) state_d = DONE;
`ifdef SAR_EARLY_EXIT_EN
          // Bits below idx are never set yet, so stopping here leaves them 0.
          if (equal_i) state_d = DONE;
`endif
        end
        if (state_d == DONE) begin
          result_d = acc_d;
          rfound_d = found_d;
          rerr_d   = err_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trial_o = '0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      PROBE: begin
        trial_o = acc_q | probe_bit;
        busy_o  = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign result_o = result_q;
  assign found_o  = rfound_q;
  assign err_o    = rerr_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// +----------------------------------------------------------------------+
// | tb_sar_search : scoreboard bench for sar_search with a comparator     |
// |                 model and optional verdict fault injection.           |
// | Rev 1.0       : initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sar_search;
  import sar_pkg::*;

  localparam int W = SAR_WIDTH;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] trial;
  logic         greater, less, equal;
  logic         busy, done, found, err;
  logic [W-1:0] result;

  sar_search #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .trial_o  (trial),
    .greater_i(greater),
    .less_i   (less),
    .equal_i  (equal),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .found_o  (found),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] target;
    int           c;
    logic [W-1:0] res;
    logic         fnd;
    logic         er;
    int           probes;
  } exp_t;

  exp_t q[$];
  int vec = 0, miss = 0, cyc = 0, pc = 1, to_cnt = 0, to_seen = 0, bcnt = 0;
  logic [W-1:0] cur_target = '0;
  int           cur_fault  = 0;
  bit           cur_kind   = 1'b0;
  exp_t         m_e;

  always @(posedge clk) cyc <= cyc + 1;

  // 1-based probe number of the current PROBE cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 1;
    else if (busy) pc <= pc + 1;
    else pc <= 1;

  // External comparator, optionally corrupted on one chosen probe
  always_comb begin
    greater = cur_target > trial;
    less    = cur_target < trial;
    equal   = cur_target == trial;
    if (busy && cur_fault == pc) begin
      if (cur_kind) begin
        greater = 1'b0;
        less    = 1'b0;
        equal   = 1'b0;
      end else begin
        greater = 1'b1;
        less    = 1'b1;
      end
    end
  end

  function automatic logic [W-1:0] hi_bits(logic [W-1:0] v, int n);
    logic [W-1:0] m = '0;
    for (int i = 0; i < n; i++) m[W-1-i] = 1'b1;
    return v & m;
  endfunction

  function automatic logic [W-1:0] exp_trial(logic [W-1:0] t, int j);
    return hi_bits(t, j - 1) | (W'(1) << (W - j));
  endfunction

  function automatic exp_t model(logic [W-1:0] t, int fault, int c);
    exp_t e;
    int hit = 0;
    int stop = W;
    for (int i = W - 1; i >= 0; i--) if (t[i]) hit = W - i;
`ifdef SAR_EARLY_EXIT_EN
    if (hit != 0) stop = hit;
`endif
    e.target = t;
    e.c      = c;
    if (fault != 0 && fault <= stop) begin
      e.er     = 1'b1;
      e.probes = fault;
      e.res    = hi_bits(t, fault - 1);
      e.fnd    = (hit != 0) && (hit < fault);
    end else begin
      e.er     = 1'b0;
      e.probes = stop;
      e.res    = t;
      e.fnd    = (hit != 0);
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (to_cnt != to_seen) begin
      to_seen++;
      vec++;
      miss++;
      $display("FAIL timeout: search did not complete, got no done expected done");
    end
    if (!rst_n) begin
      check("reset_outputs", 32'({trial, busy, done, result, found, err}), 32'd0);
      bcnt = 0;
    end else begin
      if (busy) begin
        bcnt++;
        if (q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL busy_unexpected: got busy=1 expected busy=0");
        end else begin
          check("trial", 32'(trial), 32'(exp_trial(q[0].target, bcnt)));
          check("probe_cycle", cyc, q[0].c + bcnt);
        end
      end else begin
        check("idle_trial", 32'(trial), 32'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL done_unexpected: got done=1 expected done=0");
        end else begin
          m_e = q.pop_front();
          check("result", 32'(result), 32'(m_e.res));
          check("found", 32'(found), 32'(m_e.fnd));
          check("err", 32'(err), 32'(m_e.er));
          check("done_cycle", cyc, m_e.c + m_e.probes + 1);
          check("busy_cycles", bcnt, m_e.probes);
        end
        bcnt = 0;
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      to_cnt++;
      q.delete();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(logic [W-1:0] t, int fault, bit kind);
    cur_target = t;
    cur_fault  = fault;
    cur_kind   = kind;
    start      = 1'b1;
    q.push_back(model(t, fault, cyc));
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    logic [W-1:0] t;
    int           f;
    int           base;
    exp_t         e;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'hA5, 0, 1'b0);
    issue(8'h80, 0, 1'b0);
    issue(8'h00, 0, 1'b0);
    issue(8'hFF, 0, 1'b0);
    issue(8'h5A, 3, 1'b0);
    issue(8'h3C, 6, 1'b1);
    issue(8'h01, 8, 1'b0);

    repeat (40) begin
      t = W'($urandom_range(0, 255));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      issue(t, f, 1'($urandom_range(0, 1)));
    end

    // start held high across three back-to-back searches
    t          = W'($urandom_range(0, 255));
    cur_target = t;
    cur_fault  = 0;
    start      = 1'b1;
    base       = cyc;
    for (int i = 0; i < 3; i++) begin
      e = model(t, 0, base);
      q.push_back(e);
      base = base + e.probes + 2;
    end
    wait_drain();
    start = 1'b0;
    @(posedge clk); #1;

    // reset asserted during probe cycle 5
    t          = W'($urandom_range(0, 255)) | W'(1);
    cur_target = t;
    cur_fault  = 0;
    start      = 1'b1;
    q.push_back(model(t, 0, cyc));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    q.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(W'($urandom_range(0, 255)), 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine: the inverse of the 8-bit magnitude comparator. It drives a trial value into an external comparator and reads back the greater/less/equal verdict. It converges on the unknown operand held on the comparator's other input, MSB first, one bit per cycle. It sits beside the comparator in the datapath top level and turns the combinational three-way compare into a sequential value-recovery function.

## Interface
- WIDTH, 8, operand width in bits; also the number of probe cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a search; sampled only in IDLE.
- trial  out  WIDTH  value driven to the comparator's second operand.
- greater  in  1  comparator verdict: target > trial.
- less  in  1  comparator verdict: target < trial.
- equal  in  1  comparator verdict: target == trial.
- busy  out  1  high while probing.
- done  out  1  one-cycle pulse when a search terminates.
- result  out  WIDTH  recovered target; held until the next accepted start.
- found  out  1  an equal verdict was observed during the search; held with result.
- err  out  1  an inconsistent verdict aborted the search; held with result.

## Operation
- FSM states: IDLE, PROBE, DONE. Encoding is defined in the package.
- IDLE: trial = 0. When start = 1, clear acc, found and err, set bit index to WIDTH-1, and go to PROBE.
- PROBE: trial = acc | (1 << idx). The verdict is sampled at the clock edge that ends the cycle.
  - greater or equal: keep the bit (acc |= 1 << idx).
  - less: drop the bit.
  - equal also sets found.
  - idx decrements each probe. After the idx = 0 probe, go to DONE.
- Consistency check: exactly one of greater/less/equal must be high in every PROBE cycle.
  - If zero or more than one is high, set err, leave acc unmodified for that bit, and go to DONE immediately.
- DONE: result = acc, done = 1, trial = 0. Go to IDLE next cycle.
- start is ignored outside IDLE, including the DONE cycle.
- The verdict inputs are ignored outside PROBE.
- With a consistent comparator, result always equals the target, including targets 0x00 and 0xFF.
- found = 0 with err = 0 means the target was recovered but never hit exactly, e.g. target 0x00.

## Timing
- Reset values: state IDLE, trial 0, busy 0, done 0, result 0, found 0, err 0.
- start is sampled at edge E0. Probe cycles are cycles 1..WIDTH. done pulses in cycle WIDTH+1, and result/found/err update at that same edge. The state is IDLE from cycle WIDTH+2.
- start can next be accepted in cycle WIDTH+2; back-to-back search period is WIDTH+2 cycles.
- busy = 1 exactly in PROBE cycles. trial is combinational from registered state and stable for the whole cycle.
- The comparator path trial -> verdict is combinational and must close within one cycle.
- Reset asserted mid-search: immediate abort, all outputs to reset values, no done pulse.
- An error on probe k terminates at the end of that cycle; done follows in cycle k+1.

## Configuration
- SAR_EARLY_EXIT_EN defined: an equal verdict in PROBE terminates the search.
  - acc takes the kept bit, remaining lower bits are forced to 0, found = 1, and the FSM goes to DONE.
  - Latency is 1 + (probes used) cycles to done.
- SAR_EARLY_EXIT_EN undefined: always WIDTH probes. Equal is treated as greater for bit keeping and sets found.

## Structure
- Package sar_pkg: state enum (IDLE, PROBE, DONE), the default WIDTH constant, and a constant for the idx counter width, $clog2(WIDTH).
- Single module, no sub-module. The comparator is instantiated by the parent, not inside sar_search.

## Test plan
- Target 0xA5, macro off: trial sequence 0x80,C0,A0,B0,A8,A4,A6,A5 in cycles 1..8; done in cycle 9; result 0xA5, found 1, err 0.
- Target 0x80, macro on: equal in cycle 1; done in cycle 2; result 0x80, found 1. Same target with macro off: 8 probes, result 0x80, found 1.
- Targets 0x00 and 0xFF, macro off: result 0x00 with found 0, and result 0xFF with found 1. busy is high for exactly 8 cycles.
- Force greater and less both to 1 in probe cycle 3 for target 0x5A: err 1, done in cycle 4, result 0x40.
- start held high continuously: searches begin every 10 cycles; start during PROBE or DONE has no effect.
- Assert rst_n low in probe cycle 5: all outputs 0 immediately, no done; a new start after release completes normally.
